therm_decoder: RTL and testbench

//  Receiving end of the thermometer code: bit i = 0 for i < x, 1 for i >= x.

---
 rtl/therm_pkg.sv | 62 ++++++
 rtl/therm_decoder_core.sv | 35 +++
 rtl/therm_decoder.sv | 97 +++++++++
 tb/tb_therm_decoder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/therm_pkg.sv
// therm_pkg: shared definitions for the thermometer decoder.
//   THERM_N      default thermometer width
//   THERM_CNT_W  count width for the default width
//   THERM_WMAX   widest word the decode helpers accept
//   therm_cnt_t  decoded count type for the default width
//   f_first_one  index of the lowest 1 bit (n when the word is all zeros)
//   f_zero_count number of 0 bits among the low n bits
//   f_is_bubble  1 when some 1 bit sits below a 0 bit
package therm_pkg;

    localparam int unsigned THERM_N     = 5;
    localparam int unsigned THERM_CNT_W = $clog2(THERM_N + 1);
    localparam int unsigned THERM_WMAX  = 32;

    typedef logic [THERM_CNT_W-1:0] therm_cnt_t;

    function automatic int unsigned f_first_one(input logic [THERM_WMAX-1:0] w,
                                                input int unsigned n);
        int unsigned idx;
        logic        found;
        idx   = n;
        found = 1'b0;
        for (int unsigned i = 0; i < THERM_WMAX; i++) begin
            if (i < n && w[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic int unsigned f_zero_count(input logic [THERM_WMAX-1:0] w,
                                                 input int unsigned n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < THERM_WMAX; i++) begin
            if (i < n && !w[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

    function automatic logic f_is_bubble(input logic [THERM_WMAX-1:0] w,
                                         input int unsigned n);
        logic seen_one;
        logic bub;
        seen_one = 1'b0;
        bub      = 1'b0;
        for (int unsigned i = 0; i < THERM_WMAX; i++) begin
            if (i < n) begin
                if (w[i]) begin
                    seen_one = 1'b1;
                end else if (seen_one) begin
                    bub = 1'b1;
                end
            end
        end
        return bub;
    endfunction

endpackage

// File: rtl/therm_decoder_core.sv
// therm_decode_core: combinational thermometer word -> {count, bubble}.
// Ports:
//   therm   in  N      thermometer word (bit i = 1 for i >= x)
//   count   out CNT_W  decoded value x
//   bubble  out 1      word is malformed (a 1 below a 0)
// Build option: THERM_DEC_BUBBLE_FIX_EN selects zero-count decode, which is
// tolerant of bubbles; otherwise the lowest-1 index is used.
module therm_decode_core
    import therm_pkg::*;
#(
    parameter int unsigned N     = THERM_N,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     therm,
    output logic [CNT_W-1:0] count,
    output logic             bubble
);

    logic [THERM_WMAX-1:0] wide;

    always_comb begin
        wide         = '0;
        wide[N-1:0]  = therm;
    end

    always_comb begin
`ifdef THERM_DEC_BUBBLE_FIX_EN
        count  = CNT_W'(f_zero_count(wide, N));
`else
        count  = CNT_W'(f_first_one(wide, N));
`endif
        bubble = f_is_bubble(wide, N);
    end

endmodule

// File: rtl/therm_decoder.sv
// therm_decoder: two-stage pipelined thermometer-to-binary decoder with
// valid/ready handshakes and a saturating bubble (malformed word) counter.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   in_valid    in   input word valid
//   in_ready    out  input can be accepted this cycle
//   in_therm    in   N-bit thermometer word
//   out_valid   out  decoded result valid
//   out_ready   in   consumer accepts result
//   out_count   out  decoded value x (0..N)
//   out_bubble  out  word was malformed
//   err_clr     in   clear error counter (wins over an increment)
//   err_cnt     out  saturating count of bubble words handed out
// Build option: THERM_DEC_BUBBLE_FIX_EN (see therm_decode_core).
module therm_decoder
    import therm_pkg::*;
#(
    parameter int unsigned N     = THERM_N,
    parameter int unsigned CNT_W = $clog2(N + 1),
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_therm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_bubble,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt
);

    logic             s1_valid;
    logic [N-1:0]     s1_therm;
    logic [CNT_W-1:0] dec_count;
    logic             dec_bubble;
    logic             in_fire;
    logic             s2_load;
    logic             out_fire;

    // Stage 2 takes a word whenever it is empty or draining this cycle, so
    // stage 1 can accept a new word in the same cycle it hands one on.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    therm_decode_core #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_core (
        .therm  (s1_therm),
        .count  (dec_count),
        .bubble (dec_bubble)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_therm <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_therm <= in_therm;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_count  <= '0;
            out_bubble <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid  <= 1'b1;
                out_count  <= dec_count;
                out_bubble <= dec_bubble;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt <= '0;
        end else if (out_fire && out_bubble && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_therm_decoder.sv
module tb_therm_decoder;

    localparam int N     = 5;
    localparam int CNT_W = 3;
    localparam int ERR_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_therm = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] out_count;
    logic             out_bubble;
    logic             err_clr = 1'b0;
    logic [ERR_W-1:0] err_cnt;

    therm_decoder #(
        .N     (N),
        .CNT_W (CNT_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_therm   (in_therm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_bubble (out_bubble),
        .err_clr    (err_clr),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: x is the number of leading zeros from bit 0; a word is
    // legal only if it equals all-ones shifted left by some k in 0..N.
    function automatic int model_bubble(input int w);
        int mask;
        mask = (1 << N) - 1;
        for (int k = 0; k <= N; k++) begin
            if (w == ((mask << k) & mask)) return 0;
        end
        return 1;
    endfunction

    function automatic int model_count(input int w);
`ifdef THERM_DEC_BUBBLE_FIX_EN
        return N - $countones(w);
`else
        if (w == 0) return N;
        return $clog2(w & -w);
`endif
    endfunction

    // Monitor / scoreboard state
    int  exp_q[$];
    int  obs_count[$];
    int  obs_bub[$];
    int  obs_cyc[$];
    int  in_cyc[$];
    int  cyc = 0;
    int  exp_err = 0;
    bit  mon_on = 1'b0;
    bit  prev_rst = 1'b0;
    bit  prev_hold = 1'b0;
    int  prev_count = 0;
    int  prev_bub = 0;
    bit  rand_en = 1'b0;

    always @(negedge clk) begin
        int w;
        cyc++;
        if (mon_on) begin
            chk("err_cnt_model", int'(err_cnt), exp_err);
            if (prev_rst) begin
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_in_ready", int'(in_ready), 1);
                chk("rst_out_count", int'(out_count), 0);
                chk("rst_out_bubble", int'(out_bubble), 0);
            end else if (prev_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_count", int'(out_count), prev_count);
                chk("hold_bubble", int'(out_bubble), prev_bub);
            end
            if (rst) begin
                exp_q.delete();
                exp_err = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_output", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        chk("sb_count", int'(out_count), model_count(w));
                        chk("sb_bubble", int'(out_bubble), model_bubble(w));
                        if (err_clr) exp_err = 0;
                        else if (model_bubble(w) == 1 && exp_err < ERR_MAX) exp_err++;
                    end
                    obs_count.push_back(int'(out_count));
                    obs_bub.push_back(int'(out_bubble));
                    obs_cyc.push_back(cyc);
                end else if (err_clr) begin
                    exp_err = 0;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(int'(in_therm));
                    in_cyc.push_back(cyc);
                end
            end
        end
        prev_rst   = rst;
        prev_hold  = out_valid && !out_ready && !rst;
        prev_count = int'(out_count);
        prev_bub   = int'(out_bubble);
    end

    always @(posedge clk) begin
        #1;
        if (rand_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic clear_logs();
        obs_count.delete();
        obs_bub.delete();
        obs_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        err_clr = 1'b0;
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    // Presents a word until accepted; leaves in_valid high on return.
    task automatic push(input int w);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_therm = N'(w);
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    int wv[4];
    int acc;
    bit seen;
    int nbub;

    initial begin
        tick();
        rst = 1'b0;
        mon_on = 1'b1;
        do_reset();

        // Test 1: legal codes back to back
        out_ready = 1'b1;
        push(5'b11100);
        push(5'b00000);
        push(5'b11111);
        drain(5);
        chk("t1_nout", obs_count.size(), 3);
        if (obs_count.size() >= 3 && in_cyc.size() >= 1) begin
            chk("t1_c0", obs_count[0], 2);
            chk("t1_c1", obs_count[1], 5);
            chk("t1_c2", obs_count[2], 0);
            chk("t1_lat", obs_cyc[0] - in_cyc[0], 2);
            chk("t1_b2b1", obs_cyc[1] - obs_cyc[0], 1);
            chk("t1_b2b2", obs_cyc[2] - obs_cyc[1], 1);
            chk("t1_bub", obs_bub[0] + obs_bub[1] + obs_bub[2], 0);
        end

        // Test 2: bubble word
        do_reset();
        push(5'b10100);
        drain(5);
        chk("t2_nout", obs_count.size(), 1);
        if (obs_count.size() >= 1) begin
`ifdef THERM_DEC_BUBBLE_FIX_EN
            chk("t2_count", obs_count[0], 3);
`else
            chk("t2_count", obs_count[0], 2);
`endif
            chk("t2_bubble", obs_bub[0], 1);
        end
        chk("t2_err", int'(err_cnt), 1);

        // Test 3: backpressure
        do_reset();
        wv[0] = 5'b11110; wv[1] = 5'b11000; wv[2] = 5'b10000; wv[3] = 5'b00000;
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (acc < 4);
            in_therm = N'(wv[acc < 4 ? acc : 0]);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            tick();
        end
        chk("t3_accepted", acc, 2);
        chk("t3_in_ready", int'(in_ready), 0);
        chk("t3_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            in_valid = (acc < 4);
            in_therm = N'(wv[acc < 4 ? acc : 0]);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            tick();
        end
        drain(5);
        chk("t3_nout", obs_count.size(), 4);
        if (obs_count.size() >= 4) begin
            chk("t3_c0", obs_count[0], 1);
            chk("t3_c1", obs_count[1], 3);
            chk("t3_c2", obs_count[2], 4);
            chk("t3_c3", obs_count[3], 5);
        end

        // Test 4: saturation, then clear coincident with a bubble handshake
        do_reset();
        out_ready = 1'b1;
        acc = 0;
        in_valid = 1'b1;
        in_therm = 5'b10100;
        for (int c = 0; c < 400 && acc < 260; c++) begin
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        drain(5);
        chk("t4_sat", int'(err_cnt), 255);
        out_ready = 1'b0;
        push(5'b01000);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = out_valid;
            tick();
        end
        if (!seen) chk("t4_wait_timeout", 0, 1);
        out_ready = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_clr_wins", int'(err_cnt), 0);
        tick();

        // Test 5: reset with both stages full
        do_reset();
        out_ready = 1'b0;
        push(5'b10100);
        push(5'b10100);
        in_valid = 1'b0;
        tick();
        chk("t5_full", int'(in_ready), 0);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
        @(negedge clk);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_in_ready", int'(in_ready), 1);
        chk("t5_err", int'(err_cnt), 0);
        tick();
        push(5'b11000);
        drain(5);
        chk("t5_nout", obs_count.size(), 1);
        if (obs_count.size() >= 1) chk("t5_count", obs_count[0], 3);

        // Test 6: all 32 words under random valid/ready
        do_reset();
        rand_en = 1'b1;
        for (int w = 0; w < 32; w++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            push(w);
        end
        in_valid = 1'b0;
        repeat (40) tick();
        rand_en = 1'b0;
        out_ready = 1'b1;
        drain(10);
        chk("t6_nout", obs_count.size(), 32);
        chk("t6_pending", exp_q.size(), 0);
        nbub = 0;
        foreach (obs_bub[i]) nbub += obs_bub[i];
        chk("t6_nbubble", nbub, 26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
